// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the default
// width/timeout parameters used by mem_port_arbiter and mem_arb_pick.
package mem_arb_pkg;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 15;

  // Legacy-compatible state encodings; the enum below is built on them.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    WAIT = ST_WAIT
  } state_t;

  typedef enum logic [0:0] {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  // The requester that is not o.
  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_LS) ? OWN_IF : OWN_LS;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store requesters.
// Default: fixed priority, LS over IF.
// With MEM_ARB_RR_EN defined: on simultaneous requests the requester that
// was not granted last wins; a lone requester always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   ls_req,
`ifdef MEM_ARB_RR_EN
  input  owner_e last_owner,
`endif
  output logic   req_any,
  output owner_e winner
);

  // Resolve which requester owns the port if a grant happens this cycle.
  always_comb begin
    req_any = if_req | ls_req;
    winner  = OWN_IF;
    if (if_req && ls_req) begin
`ifdef MEM_ARB_RR_EN
      winner = other_owner(last_owner);
`else
      winner = OWN_LS;
`endif
    end else if (ls_req) begin
      winner = OWN_LS;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS).
// One transaction outstanding at a time: a request is granted in the same
// cycle it is seen in IDLE, the FSM then waits in WAIT for mem_rvalid_i and
// routes the response to the owner. If memory stays silent for
// TIMEOUT_CYCLES counted WAIT cycles, the owner gets an error response.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration
// (default is fixed priority LS > IF).
//
// Handshake: a requester holds req/addr/data stable until it sees its gnt
// (same cycle, combinational); a grant is given only in IDLE, so a held
// request is never granted twice. The response is a single-cycle rvalid
// pulse to the owner with err flagging a timeout; rdata is 0 whenever
// rvalid is 0 or err is 1.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_err_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_be_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   ls_rdata_o,
  output logic                ls_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_rvalid_i,
  output logic                busy_o
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   req_any;
  owner_e winner;
  logic   grant;
  logic   timed_out;
  logic   resp_fire;
  logic   resp_err;

`ifdef MEM_ARB_RR_EN
  owner_e last_q;

  // Round-robin pointer: remembers who was granted most recently.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= OWN_IF;
    end else if (grant) begin
      last_q <= winner;
    end
  end
`endif

  mem_arb_pick u_pick (
    .if_req     (if_req_i),
    .ls_req     (ls_req_i),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_q),
`endif
    .req_any    (req_any),
    .winner     (winner)
  );

  // Grant and response qualifiers shared by the FSM and the output muxes.
  always_comb begin
    grant     = (state_q == IDLE) && req_any;
    timed_out = (state_q == WAIT) && (cnt_q == CNT_MAX);
    resp_fire = (state_q == WAIT) && (mem_rvalid_i || timed_out);
    // A real response wins over a simultaneous timeout.
    resp_err  = !mem_rvalid_i;
  end

  // Next-state logic: IDLE grants and moves to WAIT, WAIT ends on response.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = WAIT;
          owner_d = winner;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (resp_fire) begin
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          // Saturating: the counter never wraps back to zero.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, owner and timeout counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request side: grant strobe plus the winner's fields onto the memory port.
  always_comb begin
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (grant) begin
      mem_req_o = 1'b1;
      if (winner == OWN_LS) begin
        ls_gnt_o    = 1'b1;
        mem_we_o    = ls_we_i;
        mem_addr_o  = ls_addr_i;
        mem_wdata_o = ls_wdata_i;
        mem_be_o    = ls_be_i;
      end else begin
        // Fetches are always full-word reads.
        if_gnt_o   = 1'b1;
        mem_addr_o = if_addr_i;
        mem_be_o   = '1;
      end
    end
  end

  // Response side: route the memory response (or timeout error) to the owner.
  always_comb begin
    if_rvalid_o = 1'b0;
    if_err_o    = 1'b0;
    if_rdata_o  = '0;
    ls_rvalid_o = 1'b0;
    ls_err_o    = 1'b0;
    ls_rdata_o  = '0;
    if (resp_fire) begin
      if (owner_q == OWN_LS) begin
        ls_rvalid_o = 1'b1;
        ls_err_o    = resp_err;
        ls_rdata_o  = resp_err ? '0 : mem_rdata_i;
      end else begin
        if_rvalid_o = 1'b1;
        if_err_o    = resp_err;
        if_rdata_o  = resp_err ? '0 : mem_rdata_i;
      end
    end
  end

  // A transaction is outstanding for the whole time the FSM sits in WAIT.
  always_comb begin
    busy_o = (state_q == WAIT);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// The bench plays both requesters and the memory. For every transaction it
// predicts the winner from the arbitration rule, the mem-port fields, and
// the response cycle (memory latency, or TIMEOUT_CYCLES+1 cycles after the
// grant when memory never answers). Expected responses go through exp_q.
// Define MEM_ARB_RR_EN for both bench and RTL to check round-robin mode.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int T      = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              if_req_i = 1'b0;
  logic [ADDR_W-1:0] if_addr_i = '0;
  logic              if_gnt_o, if_rvalid_o, if_err_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              ls_req_i = 1'b0;
  logic              ls_we_i = 1'b0;
  logic [ADDR_W-1:0] ls_addr_i = '0;
  logic [DATA_W-1:0] ls_wdata_i = '0;
  logic [BE_W-1:0]   ls_be_i = '0;
  logic              ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mem_rvalid_i = 1'b0;
  logic              busy_o;

  int vectors     = 0;
  int miscompares = 0;
  bit last_ls     = 1'b0;          // model: most recent grant went to LS
  logic [DATA_W:0] exp_q[$];       // {err, rdata} per outstanding transaction

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .busy_o(busy_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " if_rvalid"}, if_rvalid_o, 0);
    check({tag, " if_err"},    if_err_o,    0);
    check({tag, " if_rdata"},  if_rdata_o,  0);
    check({tag, " ls_rvalid"}, ls_rvalid_o, 0);
    check({tag, " ls_err"},    ls_err_o,    0);
    check({tag, " ls_rdata"},  ls_rdata_o,  0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_if(input logic [ADDR_W-1:0] a);
    if_req_i  = 1'b1;
    if_addr_i = a;
  endtask

  task automatic drive_ls(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    ls_req_i   = 1'b1;
    ls_we_i    = we;
    ls_addr_i  = a;
    ls_wdata_i = d;
    ls_be_i    = be;
  endtask

  // Reference arbitration rule.
  function automatic bit model_pick_ls();
    if (if_req_i && ls_req_i) begin
`ifdef MEM_ARB_RR_EN
      return !last_ls;
`else
      return 1'b1;
`endif
    end
    return ls_req_i;
  endfunction

  function automatic int rand_lat();
    if ($urandom_range(0, 7) == 0) return 0;
    return $urandom_range(1, T + 1);
  endfunction

  // A cycle with no pending request: nothing granted, nothing returned.
  task automatic idle_cycle();
    @(negedge clk);
    check("idle if_gnt", if_gnt_o, 0);
    check("idle ls_gnt", ls_gnt_o, 0);
    check("idle mem_req", mem_req_o, 0);
    check("idle busy", busy_o, 0);
    check_quiet("idle");
    step();
    mem_rvalid_i = 1'b0;
  endtask

  // One full transaction. Called just after a rising edge with at least one
  // request driven. lat = cycles from grant to mem_rvalid_i (0 = never).
  // stray drives a late rvalid in the idle cycle after the response.
  task automatic txn(input int lat, input logic [DATA_W-1:0] rd, input bit stray);
    bit win_ls;
    logic [DATA_W:0] e;
    bit resp_now;
    win_ls = model_pick_ls();
    @(negedge clk);
    check("grant if_gnt", if_gnt_o, !win_ls);
    check("grant ls_gnt", ls_gnt_o, win_ls);
    check("grant mem_req", mem_req_o, 1);
    check("grant busy", busy_o, 0);
    if (win_ls) begin
      check("ls mem_we",    mem_we_o,    ls_we_i);
      check("ls mem_addr",  mem_addr_o,  ls_addr_i);
      check("ls mem_wdata", mem_wdata_o, ls_wdata_i);
      check("ls mem_be",    mem_be_o,    ls_be_i);
    end else begin
      check("if mem_we",   mem_we_o,   0);
      check("if mem_addr", mem_addr_o, if_addr_i);
      check("if mem_be",   mem_be_o,   {BE_W{1'b1}});
    end
    check_quiet("grant");
    if (lat == 0) e = {1'b1, {DATA_W{1'b0}}};
    else          e = {1'b0, rd};
    exp_q.push_back(e);
    last_ls = win_ls;
    step();
    if (win_ls) ls_req_i = 1'b0;
    else        if_req_i = 1'b0;
    for (int k = 1; k <= T + 1; k++) begin
      resp_now     = (lat != 0) && (k == lat);
      mem_rvalid_i = resp_now;
      mem_rdata_i  = resp_now ? rd : DATA_W'($urandom);
      @(negedge clk);
      check("wait if_gnt", if_gnt_o, 0);
      check("wait ls_gnt", ls_gnt_o, 0);
      check("wait mem_req", mem_req_o, 0);
      check("wait busy", busy_o, 1);
      if (resp_now || k == T + 1) begin
        e = exp_q.pop_front();
        if (win_ls) begin
          check("resp ls_rvalid", ls_rvalid_o, 1);
          check("resp ls_err",    ls_err_o,    e[DATA_W]);
          check("resp ls_rdata",  ls_rdata_o,  e[DATA_W-1:0]);
          check("resp if_rvalid", if_rvalid_o, 0);
          check("resp if_err",    if_err_o,    0);
          check("resp if_rdata",  if_rdata_o,  0);
        end else begin
          check("resp if_rvalid", if_rvalid_o, 1);
          check("resp if_err",    if_err_o,    e[DATA_W]);
          check("resp if_rdata",  if_rdata_o,  e[DATA_W-1:0]);
          check("resp ls_rvalid", ls_rvalid_o, 0);
          check("resp ls_err",    ls_err_o,    0);
          check("resp ls_rdata",  ls_rdata_o,  0);
        end
        break;
      end else begin
        check_quiet("wait");
      end
      step();
    end
    step();
    mem_rvalid_i = stray;
    mem_rdata_i  = DATA_W'($urandom);
  endtask

  task automatic apply_reset();
    if_req_i     = 1'b0;
    ls_req_i     = 1'b0;
    mem_rvalid_i = 1'b0;
    reset_n      = 1'b0;
    last_ls      = 1'b0;
    @(negedge clk);
    check("rst if_gnt", if_gnt_o, 0);
    check("rst ls_gnt", ls_gnt_o, 0);
    check("rst mem_req", mem_req_o, 0);
    check("rst mem_we", mem_we_o, 0);
    check("rst mem_addr", mem_addr_o, 0);
    check("rst mem_wdata", mem_wdata_o, 0);
    check("rst mem_be", mem_be_o, 0);
    check("rst busy", busy_o, 0);
    check_quiet("rst");
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset
    step();
    apply_reset();
    step();

    // Single fetch, memory answers two cycles after the grant.
    drive_if(32'h100);
    txn(2, 32'hDEADBEEF, 1'b0);

    // Store with partial byte enables; ack on the first possible cycle.
    drive_ls(1'b1, 32'h40, 32'h1234, 4'b0011);
    txn(1, DATA_W'($urandom), 1'b0);

    // Contention: both held and re-raised, then LS stops asking.
    for (int i = 0; i < 4; i++) begin
      if (!if_req_i) drive_if(ADDR_W'(32'h200 + i * 4));
      if (!ls_req_i) drive_ls(1'b0, ADDR_W'(32'h800 + i * 4), '0, 4'hF);
      txn($urandom_range(1, 3), DATA_W'($urandom), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      if (if_req_i || ls_req_i) txn(1, DATA_W'($urandom), 1'b0);
    end

    // Response arriving in the same cycle the counter expires is normal.
    drive_ls(1'b0, 32'h900, '0, 4'hF);
    txn(T + 1, 32'hCAFEF00D, 1'b0);

    // Timeout, followed by a late rvalid in IDLE that must be ignored.
    drive_if(32'h300);
    txn(0, '0, 1'b1);
    idle_cycle();

    // Reset during WAIT, then a stray rvalid, then a normal transaction.
    drive_ls(1'b0, 32'h500, '0, 4'hF);
    @(negedge clk);
    check("midrst ls_gnt", ls_gnt_o, 1);
    step();
    ls_req_i = 1'b0;
    step();
    step();
    @(negedge clk);
    check("midrst busy before", busy_o, 1);
    #1;
    apply_reset();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h55AA55AA;
    idle_cycle();
    drive_if(32'h600);
    txn(3, 32'h0BADF00D, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      if (!if_req_i && $urandom_range(0, 1) == 1) drive_if(ADDR_W'($urandom));
      if (!ls_req_i && $urandom_range(0, 1) == 1)
        drive_ls(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
                 BE_W'($urandom_range(0, 15)));
      if (if_req_i || ls_req_i) txn(rand_lat(), DATA_W'($urandom), $urandom_range(0, 3) == 0);
      else idle_cycle();
    end
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    idle_cycle();

    check("exp_q drained", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch requester and the load/store unit. Accepts one request per idle cycle, grants it in the same cycle, tracks the single outstanding transaction and routes the memory response back to its owner. A timeout counter returns an error response if memory never answers.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 15, max WAIT cycles before error response (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  DATA_W  fetch read data
- if_err_o  out  1  fetch response is timeout error
- ls_req_i  in  1  load/store request
- ls_we_i  in  1  1 = store
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  DATA_W  store data
- ls_be_i  in  DATA_W/8  byte enables
- ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o  out  as fetch equivalents
- mem_req_o  out  1  memory request strobe (one cycle per transaction)
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  muxed request fields
- mem_rdata_i  in  DATA_W  memory read data
- mem_rvalid_i  in  1  memory response (reads and store acks)
- busy_o  out  1  transaction outstanding

## Operation
- FSM states: IDLE, WAIT. Owner register: OWN_IF / OWN_LS.
- IDLE: if any request, pick winner, assert its gnt_o and mem_req_o combinationally with winner's fields; register owner; next state WAIT, timeout counter cleared. Fetch grants drive mem_we_o=0, mem_be_o=all ones.
- WAIT: mem_req_o=0, both gnt_o=0, busy_o=1. Counter increments each cycle.
- mem_rvalid_i in WAIT: owner's rvalid_o=1, rdata_o=mem_rdata_i, err_o=0 (combinational pass-through); next state IDLE.
- Counter reaching TIMEOUT_CYCLES without rvalid: owner's rvalid_o=1, err_o=1, rdata_o=0; next state IDLE.
- rvalid and timeout in same cycle: normal response, err_o=0.
- mem_rvalid_i in IDLE (late/stray) ignored; no rvalid_o pulse.
- Non-owner rvalid_o/err_o always 0; rdata_o outputs 0 when their rvalid_o is 0.
- Requesters hold req/addr/data stable until gnt; arbiter never grants twice for one held request in the grant cycle.
- Default arbitration: fixed priority, LS over IF.

## Timing
- Reset: all outputs 0, state IDLE, owner OWN_IF, counter 0, RR pointer = last-owner OWN_IF.
- Grant latency 0 cycles from req in IDLE; response latency = memory latency (≥1 cycle after grant).
- No back-to-back: after response cycle, next grant earliest the following cycle; minimum 2 cycles per transaction.
- Reset mid-WAIT: transaction dropped, no response delivered; subsequent stray rvalid ignored.
- Counter width $clog2(TIMEOUT_CYCLES+1); saturates, never wraps.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on simultaneous requests, grant the requester not granted last; pointer updates on every grant. Single requester always granted.
- Undefined: fixed priority LS > IF; pointer logic absent.

## Structure
- Package mem_arb_pkg: state_t enum {IDLE, WAIT}, owner_e enum {OWN_IF, OWN_LS}, default width/timeout localparams.
- Sub-module mem_arb_pick: combinational winner selection (fixed or RR, taking last-owner input); rest is top-level FSM, counter, muxes.

## Test plan
- Single fetch: if_req_i=1 addr 0x100, mem answers 2 cycles later 0xDEADBEEF -> if_gnt_o same cycle, if_rvalid_o=1 rdata 0xDEADBEEF err 0, ls outputs stay 0.
- Contention, macro off: both req repeatedly -> ls granted every transaction, if starves until ls_req_i drops.
- Contention, MEM_ARB_RR_EN: both held -> grants alternate LS, IF, LS, IF.
- Store: ls_we_i=1, be 4'b0011, wdata 0x1234 -> mem_we_o=1, mem_be_o=0011, ack on mem_rvalid_i -> ls_rvalid_o=1.
- Timeout: grant, no rvalid for 15 cycles -> owner rvalid_o=1 err_o=1 rdata 0; late rvalid in IDLE produces no pulse.
- Reset in WAIT then stray rvalid -> all outputs 0, no response; next request granted normally.
